// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with flush; used for the fetch buffer and the pending-PC queue.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy tracking; flush empties the FIFO and overrides push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == '0);

endmodule

// File: rtl/if_fetch_unit_chk.sv
// Simulation-only protocol and consistency checks for if_fetch_unit.
module if_fetch_unit_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset_n,
    input logic          imem_resp_valid,
    input logic          req_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] pend_count,
    input logic          pend_empty,
    input logic          pend_full,
    input logic          fb_full
);

    a_resp_needs_inflight: assert property (@(posedge clk) disable iff (!reset_n)
        imem_resp_valid |-> (inflight != '0));

    a_pending_tracks_inflight: assert property (@(posedge clk) disable iff (!reset_n)
        (pend_count == inflight) && (pend_empty == (inflight == '0)));

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        (pend_full || fb_full) |-> !req_valid);

endmodule

// File: rtl/if_fetch_unit.sv
// Multi-outstanding in-order instruction fetch with credit-based issue and redirect discard.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter int               ILEN         = ILEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               FBUF_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr
);

    localparam int CW = $clog2(FBUF_DEPTH+1);

    logic [XLEN-1:0] fetch_pc_r;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   inflight_next_s;
    logic [CW-1:0]   fb_count_s;
    logic [CW-1:0]   pend_count_s;
    logic [CW:0]     credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            resp_ok_s;
    logic            discard_s;
    logic            fb_push_s;
    logic            fb_pop_s;
    logic            fb_empty_s;
    logic            fb_full_s;
    logic            pend_empty_s;
    logic            pend_full_s;
    logic [XLEN-1:0] pend_pc_s;
    fetch_entry_t    fb_in_s;
    fetch_entry_t    fb_head_s;

    // Issue only while every outstanding request still owns a buffer slot
    always_comb begin
        credit_s        = {1'b0, inflight_r} + {1'b0, fb_count_s};
        req_valid_s     = reset_n && !redirect_valid && (credit_s < (CW+1)'(FBUF_DEPTH));
        req_fire_s      = req_valid_s && imem_req_ready;
        resp_ok_s       = imem_resp_valid && (inflight_r != '0);
        discard_s       = (drop_cnt_r != '0) || redirect_valid;
        fb_push_s       = resp_ok_s && !discard_s;
        fb_pop_s        = !fb_empty_s && id_ready;
        inflight_next_s = inflight_r + CW'(req_fire_s) - CW'(resp_ok_s);
        fb_in_s.pc      = pend_pc_s;
        fb_in_s.instr   = imem_resp_data;
    end

    // Fetch PC and counters; a redirect marks everything still outstanding as stale
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_VECTOR;
            inflight_r <= '0;
            drop_cnt_r <= '0;
        end else begin
            inflight_r <= inflight_next_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_target & ~(XLEN'(3));
                drop_cnt_r <= inflight_next_s;
            end else begin
                if (req_fire_s) fetch_pc_r <= fetch_pc_r + XLEN'(PC_INCR);
                if (resp_ok_s && (drop_cnt_r != '0)) drop_cnt_r <= drop_cnt_r - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(FBUF_DEPTH), .WIDTH(XLEN)) u_pend_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_fire_s),
        .push_data (fetch_pc_r),
        .pop       (resp_ok_s),
        .flush     (1'b0),
        .head      (pend_pc_s),
        .count     (pend_count_s),
        .full      (pend_full_s),
        .empty     (pend_empty_s)
    );

    fetch_fifo #(.DEPTH(FBUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fetch_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fb_push_s),
        .push_data (fb_in_s),
        .pop       (fb_pop_s),
        .flush     (redirect_valid),
        .head      (fb_head_s),
        .count     (fb_count_s),
        .full      (fb_full_s),
        .empty     (fb_empty_s)
    );

    if_fetch_unit_chk #(.CW(CW)) u_chk (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_resp_valid (imem_resp_valid),
        .req_valid       (req_valid_s),
        .inflight        (inflight_r),
        .pend_count      (pend_count_s),
        .pend_empty      (pend_empty_s),
        .pend_full       (pend_full_s),
        .fb_full         (fb_full_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign id_valid       = !fb_empty_s;
    assign id_pc          = fb_empty_s ? RESET_VECTOR : fb_head_s.pc;
    assign id_instr       = fb_empty_s ? {ILEN{1'b0}} : fb_head_s.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: behavioural memory with configurable latency and decode model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0), .FBUF_DEPTH(4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t       pipe[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          n_stale = 0;
    int          n_dec = 0;
    int          fires = 0;
    bit          wrap_armed = 1'b0;
    bit          wrapped = 1'b0;
    logic [31:0] exp_pc = 32'h0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, update the model, advance
    task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy, input bit idr);
        bit    resp;
        bit    fire;
        mreq_t m;
        redirect_valid  = redir;
        redirect_target = tgt;
        imem_req_ready  = rdy;
        id_ready        = idr;
        resp            = (pipe.size() > 0) && (pipe[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_fn(pipe[0].addr) : 32'hDEAD_BEEF;
        #1;
        check_val("req_valid", 32'(imem_req_valid), 32'(!redir && (pipe.size() + sb.size() < 4)));
        check_val("id_valid", 32'(id_valid), 32'(sb.size() > 0));
        if (id_valid && idr && !redir && (sb.size() > 0)) begin
            check_val("id_pc", id_pc, sb[0].pc);
            check_val("id_instr", id_instr, sb[0].instr);
            if (wrap_armed && (sb[0].pc == 32'h0)) wrapped = 1'b1;
            void'(sb.pop_front());
            n_dec++;
        end
        fire = imem_req_valid && rdy;
        if (fire) check_val("req_addr", imem_req_addr, exp_pc);
        if (resp) begin
            m = pipe.pop_front();
            if (n_stale > 0) n_stale--;
            else if (!redir) sb.push_back('{m.pc, mem_fn(m.pc)});
        end
        if (redir) begin
            sb.delete();
            n_stale = pipe.size();
            exp_pc  = {tgt[31:2], 2'b00};
        end
        if (fire) begin
            pipe.push_back('{imem_req_addr, exp_pc, cyc + mem_lat});
            exp_pc = exp_pc + 32'd4;
            fires++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        id_ready        = 1'b0;
        #1;
        check_val("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_val("rst_req_addr", imem_req_addr, 32'h0);
        check_val("rst_id_valid", 32'(id_valid), 32'h0);
        check_val("rst_id_pc", id_pc, 32'h0);
        check_val("rst_id_instr", id_instr, 32'h0);
        pipe.delete();
        sb.delete();
        n_stale = 0;
        exp_pc  = 32'h0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();

        mem_lat = 1;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        fires = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check_val("stall_fires_le4", 32'(fires <= 4), 32'h1);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        mem_lat = 3;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        mem_lat = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0203, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        mem_lat = 2;
        step(1'b1, 32'hFFFF_FFE0, 1'b1, 1'b1);
        wrap_armed = 1'b1;
        for (int i = 0; i < 60; i++)
            step(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        check_val("wrap_seen", 32'(wrapped), 32'h1);

        mem_lat = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("decoded_enough", 32'(n_dec > 60), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage for the RISC-V pipeline. It replaces the single-register PC with an in-order, multi-outstanding fetch engine. The engine issues requests to an instruction memory with arbitrary response latency and buffers returned instructions in a small FIFO. It hands {pc, instr} pairs to decode over a valid/ready handshake, and supports redirects from EX (branch/jump) with automatic discard of stale in-flight responses.

## Interface
Parameters:
- XLEN, 32: PC and address width.
- ILEN, 32: instruction width.
- RESET_VECTOR, 0: PC value after reset.
- FBUF_DEPTH, 4: fetch-buffer entries. Power of two, ≥2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  EX requests PC change this cycle.
- redirect_target  in  XLEN  new PC. Bits [1:0] are ignored and forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address, equal to the current fetch PC.
- imem_resp_valid  in  1  in-order response strobe, one per accepted request.
- imem_resp_data  in  ILEN  instruction word.
- id_valid  out  1  buffer head valid.
- id_ready  in  1  decode accepts head.
- id_pc  out  XLEN  PC of head instruction.
- id_instr  out  ILEN  head instruction.

## Operation
- State:
  - fetch_pc (XLEN).
  - inflight count (accepted requests not yet answered).
  - drop_cnt (stale responses still to discard).
  - fetch FIFO of {pc, instr}.
  - pending-PC FIFO holding the PC of each in-flight request.
- The counters are $clog2(FBUF_DEPTH+1) bits wide.
- Issue:
  - imem_req_valid = !redirect_valid && (inflight + fifo_count < FBUF_DEPTH).
  - This is a credit rule: an accepted request always has a guaranteed buffer slot.
- Request handshake (imem_req_valid && imem_req_ready):
  - fetch_pc += 4, wrapping modulo 2^XLEN.
  - inflight += 1.
  - The issued PC is pushed to the pending-PC FIFO.
- Response (imem_resp_valid):
  - inflight −= 1 and the pending PC is popped.
  - If drop_cnt > 0 or redirect_valid is high this cycle: discard, and drop_cnt −= 1 if it was nonzero.
  - Otherwise push {popped PC, imem_resp_data} into the fetch FIFO.
- Decode handshake (id_valid && id_ready): pop the fetch FIFO head.
- Redirect (redirect_valid):
  - fetch_pc ← {target[XLEN-1:2], 2'b00}.
  - The fetch FIFO is flushed.
  - drop_cnt ← inflight_next, meaning every still-outstanding request becomes stale.
  - No request is issued that cycle.
  - A decode pop in the same cycle is moot because the flush wins.
- imem_resp_valid while inflight == 0 is a protocol violation. Assert it in simulation. The RTL ignores it.

## Timing
- Reset values:
  - fetch_pc = RESET_VECTOR.
  - inflight = 0, drop_cnt = 0, FIFOs empty.
  - imem_req_valid = 0 while reset_n is low.
  - id_valid = 0, id_pc = RESET_VECTOR, id_instr = 0.
- imem_req_addr is a registered fetch_pc. The first request is presented in the first cycle after reset deassertion.
- Response-to-decode latency is 1 cycle. A response at edge N makes id_valid high after edge N, from the registered FIFO.
- Best-case throughput is 1 instruction per cycle with 1-cycle memory and id_ready held high.
- Full boundary: with fifo_count + inflight == FBUF_DEPTH, imem_req_valid is 0. It reasserts in the cycle after a decode pop.
- Empty boundary: id_valid = 0. A simultaneous push into an empty FIFO is visible the next cycle; there is no bypass.
- Simultaneous push and pop on a full FIFO is legal, and count is unchanged.
- Redirect and response in the same cycle: the response is discarded, and drop_cnt = inflight − 1.
- First post-redirect request is issued 1 cycle after the redirect cycle, at the target address.
- Reset mid-operation clears all state immediately. Memory responses arriving after reset are the integrator's responsibility; the memory must also be reset.

## Structure
- Package if_pkg holds:
  - XLEN/ILEN defaults.
  - typedef fetch_entry_t {pc, instr}.
  - the PC increment constant (4).
- Sub-module fetch_fifo: parametrised synchronous FIFO (DEPTH, type/width) with push, pop, flush, count, full and empty, using the same clock and reset.
- Instantiate it twice: fetch buffer (fetch_entry_t) and pending-PC FIFO (XLEN).
- The top level holds the PC, counters and issue/discard logic.

## Test plan
- Reset release, 1-cycle memory, id_ready=1:
  - id_pc sequence 0x0, 0x4, 0x8… at one per cycle after initial 2-cycle fill.
  - Each id_instr matches memory.
- id_ready=0 for 10 cycles with FBUF_DEPTH=4: at most 4 requests accepted, then imem_req_valid=0. After id_ready=1, order resumes without loss.
- 3-cycle latency memory, redirect to 0x100 with 3 requests in flight:
  - the 3 stale responses are discarded;
  - the next id_pc is 0x100.
- Redirect in the same cycle as a response, target 0x203: response dropped, next request address 0x200.
- imem_req_ready toggled randomly: no duplicated or skipped PCs, and the PC wraps 0xFFFF_FFFC→0x0 correctly.
- Assert reset_n mid-stream: outputs return to reset values immediately, and fetch restarts at RESET_VECTOR.
